// File: rtl/i2c_txn_arbiter.sv
// rtl/i2c_txn_arbiter.sv - whole-transaction arbiter sharing one I2C master between requesters
//
// Purpose:
//   Grants one requester at a time a complete I2C transaction (START..STOP) on a
//   shared master engine. It drives the master's control inputs, streams write
//   bytes from the owner's FIFO head, returns read bytes, and reports completion
//   with {timeout, nack} status. A watchdog aborts transactions that never return
//   the master to idle.
//
// Build option:
//   I2C_ARB_FIXED_PRIO_EN - when defined, the lowest requester index always wins
//                           and no round-robin pointer exists. Default: round-robin.
//
// Ports:
//   clk, rst       clock; asynchronous active-low reset
//   req            per-requester transaction request (level, held until done)
//   req_addr_rw    per-requester {addr[6:0], rw}, slice i = [8i+7:8i]
//   req_cnt        per-requester byte count minus 1
//   req_wdata      per-requester write FIFO head byte
//   gnt            one-hot grant for the transaction owner
//   wr_pop         1-cycle pulse: owner advances its write FIFO
//   rd_valid       1-cycle pulse: rd_data valid for the owner
//   rd_data        read byte returned from the master
//   done           1-cycle completion pulse to the owner
//   err            {timeout, nack}, valid with done
//   m_ready        master i2c_ready
//   m_addr_rw      master data_addr_rw
//   m_data_in      master data_in
//   m_data_cnt     master data_cnt
//   m_mode         master mode_i2c
//   m_status       master status {4'b0, rx_da_ack, tx_da_ack, i2c_done, idle}
//   m_data_out     master data_out

module i2c_txn_arbiter #(
   parameter int NUM_REQ     = 2,
   parameter int TIMEOUT_CYC = 1000000,
   parameter int TW          = 20
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NUM_REQ-1:0]     req,
   input  logic [NUM_REQ*8-1:0]   req_addr_rw,
   input  logic [NUM_REQ*8-1:0]   req_cnt,
   input  logic [NUM_REQ*8-1:0]   req_wdata,
   output logic [NUM_REQ-1:0]     gnt,
   output logic [NUM_REQ-1:0]     wr_pop,
   output logic [NUM_REQ-1:0]     rd_valid,
   output logic [7:0]             rd_data,
   output logic [NUM_REQ-1:0]     done,
   output logic [1:0]             err,
   output logic                   m_ready,
   output logic [7:0]             m_addr_rw,
   output logic [7:0]             m_data_in,
   output logic [7:0]             m_data_cnt,
   output logic [1:0]             m_mode,
   input  logic [7:0]             m_status,
   input  logic [7:0]             m_data_out
);

   localparam int PW  = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;
   localparam int PW1 = PW + 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_GRANT,
      S_LAUNCH,
      S_RUN,
      S_FINISH,
      S_DONE
   } state_t;

   state_t               r_state;
   logic [NUM_REQ-1:0]   r_gnt;
   logic [NUM_REQ-1:0]   r_wr_pop;
   logic [NUM_REQ-1:0]   r_rd_valid;
   logic [7:0]           r_rd_data;
   logic [NUM_REQ-1:0]   r_done;
   logic [1:0]           r_err;
   logic                 r_m_ready;
   logic [7:0]           r_m_addr_rw;
   logic [7:0]           r_m_data_in;
   logic [7:0]           r_m_data_cnt;
   logic [1:0]           r_m_mode;
   logic [2:0]           r_st_q;
   logic [8:0]           r_ack_cnt;
   logic [8:0]           r_rx_cnt;
   logic [TW-1:0]        r_wd;

   logic                 w_found;
   logic [PW-1:0]        w_win;
   logic [NUM_REQ-1:0]   w_onehot;
   logic [7:0]           w_sel_ar;
   logic [7:0]           w_sel_cnt;
   logic [7:0]           w_sel_wd;
   logic [7:0]           w_run_wd;
   logic                 w_ack_edge;
   logic                 w_rx_edge;
   logic                 w_done_edge;
   logic                 w_active;
   logic                 w_wd_hit;
   logic                 w_nack;
   logic                 w_status_unused;

   // ---------------------------------------------------------------------
   // Winner selection
   // ---------------------------------------------------------------------
`ifdef I2C_ARB_FIXED_PRIO_EN
   // Scan from the top down so the lowest set index is the last one written.
   always_comb begin
      w_found = 1'b0;
      w_win   = '0;
      for (int i = NUM_REQ-1; i >= 0; i--) begin
         if (req[i]) begin
            w_found = 1'b1;
            w_win   = PW'(i);
         end
      end
   end
`else
   logic [PW-1:0] r_ptr;
   logic [PW-1:0] w_ptr_nxt;
   logic [PW:0]   w_sum;

   // Visit indices ptr, ptr+1, ... with wrap; first requester found wins.
   always_comb begin
      w_found = 1'b0;
      w_win   = '0;
      w_sum   = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         w_sum = {1'b0, r_ptr} + PW1'(i);
         if (w_sum >= PW1'(NUM_REQ)) begin
            w_sum = w_sum - PW1'(NUM_REQ);
         end
         for (int j = 0; j < NUM_REQ; j++) begin
            if (!w_found && (w_sum == PW1'(j)) && req[j]) begin
               w_found = 1'b1;
               w_win   = PW'(j);
            end
         end
      end
   end

   assign w_ptr_nxt = (w_win == PW'(NUM_REQ-1)) ? '0 : w_win + 1'b1;
`endif

   // Slice muxes: winner's request fields at grant time, owner's FIFO head while running.
   always_comb begin
      w_onehot  = '0;
      w_sel_ar  = '0;
      w_sel_cnt = '0;
      w_sel_wd  = '0;
      w_run_wd  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (w_win == PW'(i)) begin
            w_onehot[i] = 1'b1;
            w_sel_ar    = req_addr_rw[8*i +: 8];
            w_sel_cnt   = req_cnt[8*i +: 8];
            w_sel_wd    = req_wdata[8*i +: 8];
         end
         if (r_gnt[i]) begin
            w_run_wd = req_wdata[8*i +: 8];
         end
      end
   end

   // ---------------------------------------------------------------------
   // Master status edges and completion checks
   // ---------------------------------------------------------------------
   assign w_ack_edge  = m_status[2] & ~r_st_q[1];
   assign w_rx_edge   = m_status[3] & ~r_st_q[2];
   assign w_done_edge = m_status[1] & ~r_st_q[0];

   assign w_status_unused = ^m_status[7:4];

   assign w_active = (r_state == S_LAUNCH) || (r_state == S_RUN) || (r_state == S_FINISH);
   assign w_wd_hit = (r_wd == TW'(TIMEOUT_CYC - 1));

   // The master raises tx_da_ack only when it continues, so the last written byte
   // never produces an edge: a full write sees address + cnt data acks.
   assign w_nack = r_m_addr_rw[0]
                 ? !((r_ack_cnt == 9'd1) && (r_rx_cnt == ({1'b0, r_m_data_cnt} + 9'd1)))
                 : (r_ack_cnt != ({1'b0, r_m_data_cnt} + 9'd1));

   // ---------------------------------------------------------------------
   // Transaction FSM
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state      <= S_IDLE;
         r_gnt        <= '0;
         r_wr_pop     <= '0;
         r_rd_valid   <= '0;
         r_rd_data    <= '0;
         r_done       <= '0;
         r_err        <= 2'b00;
         r_m_ready    <= 1'b0;
         r_m_addr_rw  <= '0;
         r_m_data_in  <= '0;
         r_m_data_cnt <= '0;
         r_m_mode     <= 2'b00;
         r_st_q       <= '0;
         r_ack_cnt    <= '0;
         r_rx_cnt     <= '0;
         r_wd         <= '0;
`ifdef I2C_ARB_FIXED_PRIO_EN
`else
         r_ptr        <= '0;
`endif
      end else begin
         r_st_q     <= m_status[3:1];
         r_wr_pop   <= '0;
         r_rd_valid <= '0;
         r_done     <= '0;

         if (w_active && w_wd_hit) begin
            // Abort: release the master and report timeout; nothing more is
            // popped or returned for this transaction.
            r_m_ready <= 1'b0;
            r_m_mode  <= 2'b00;
            r_done    <= r_gnt;
            r_err     <= 2'b10;
            r_wd      <= TW'(TIMEOUT_CYC);
            r_state   <= S_DONE;
         end else begin
            if (w_active) begin
               r_wd <= r_wd + 1'b1;
            end

            case (r_state)
               S_IDLE: begin
                  if (w_found && m_status[0]) begin
                     r_gnt        <= w_onehot;
                     r_m_addr_rw  <= w_sel_ar;
                     r_m_data_cnt <= w_sel_cnt;
                     r_m_data_in  <= w_sel_wd;
                     // Byte 0 is loaded now, so the owner's FIFO advances here.
                     if (!w_sel_ar[0]) begin
                        r_wr_pop <= w_onehot;
                     end
                     r_ack_cnt    <= '0;
                     r_rx_cnt     <= '0;
                     r_wd         <= '0;
`ifdef I2C_ARB_FIXED_PRIO_EN
`else
                     r_ptr        <= w_ptr_nxt;
`endif
                     r_state      <= S_GRANT;
                  end
               end

               S_GRANT: begin
                  r_m_ready <= 1'b1;
                  r_m_mode  <= 2'b10;
                  r_state   <= S_LAUNCH;
               end

               S_LAUNCH: begin
                  if (!m_status[0]) begin
                     r_state <= S_RUN;
                  end
               end

               S_RUN: begin
                  if (w_ack_edge) begin
                     r_ack_cnt <= r_ack_cnt + 9'd1;
                     // First ack is the address; each later ack releases the next byte.
                     if (!r_m_addr_rw[0] && (r_ack_cnt != 9'd0) &&
                         (r_ack_cnt <= {1'b0, r_m_data_cnt})) begin
                        r_m_data_in <= w_run_wd;
                        r_wr_pop    <= r_gnt;
                     end
                  end
                  if (w_rx_edge && r_m_addr_rw[0]) begin
                     r_rd_data  <= m_data_out;
                     r_rd_valid <= r_gnt;
                     r_rx_cnt   <= r_rx_cnt + 9'd1;
                  end
                  if (w_done_edge) begin
                     r_m_ready <= 1'b0;
                     r_m_mode  <= 2'b00;
                     r_state   <= S_FINISH;
                  end
               end

               S_FINISH: begin
                  if (m_status[0]) begin
                     r_done  <= r_gnt;
                     r_err   <= {1'b0, w_nack};
                     r_state <= S_DONE;
                  end
               end

               S_DONE: begin
                  r_gnt   <= '0;
                  r_err   <= 2'b00;
                  r_state <= S_IDLE;
               end

               default: begin
                  r_state <= S_IDLE;
               end
            endcase
         end
      end
   end

   assign gnt        = r_gnt;
   assign wr_pop     = r_wr_pop;
   assign rd_valid   = r_rd_valid;
   assign rd_data    = r_rd_data;
   assign done       = r_done;
   assign err        = r_err;
   assign m_ready    = r_m_ready;
   assign m_addr_rw  = r_m_addr_rw;
   assign m_data_in  = r_m_data_in;
   assign m_data_cnt = r_m_data_cnt;
   assign m_mode     = r_m_mode;

endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// tb/tb_i2c_txn_arbiter.sv - directed self-checking bench for i2c_txn_arbiter

module tb_i2c_txn_arbiter;

   localparam int N   = 2;
   localparam int BIT = 8;

   logic           clk = 1'b0;
   logic           rst = 1'b0;
   logic [N-1:0]   req = '0;
   logic [N*8-1:0] req_addr_rw = '0;
   logic [N*8-1:0] req_cnt = '0;
   logic [N*8-1:0] req_wdata;
   logic [N-1:0]   gnt;
   logic [N-1:0]   wr_pop;
   logic [N-1:0]   rd_valid;
   logic [7:0]     rd_data;
   logic [N-1:0]   done;
   logic [1:0]     err;
   logic           m_ready;
   logic [7:0]     m_addr_rw;
   logic [7:0]     m_data_in;
   logic [7:0]     m_data_cnt;
   logic [1:0]     m_mode;
   logic [7:0]     m_status;
   logic [7:0]     m_data_out;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   i2c_txn_arbiter #(
      .NUM_REQ    (N),
      .TIMEOUT_CYC(5000),
      .TW         (20)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .req        (req),
      .req_addr_rw(req_addr_rw),
      .req_cnt    (req_cnt),
      .req_wdata  (req_wdata),
      .gnt        (gnt),
      .wr_pop     (wr_pop),
      .rd_valid   (rd_valid),
      .rd_data    (rd_data),
      .done       (done),
      .err        (err),
      .m_ready    (m_ready),
      .m_addr_rw  (m_addr_rw),
      .m_data_in  (m_data_in),
      .m_data_cnt (m_data_cnt),
      .m_mode     (m_mode),
      .m_status   (m_status),
      .m_data_out (m_data_out)
   );

   // Requester write FIFOs
   logic [7:0] wq0 [0:15];
   logic [7:0] wq1 [0:15];
   logic [3:0] h0 = '0;
   logic [3:0] h1 = '0;
   int         pop0 = 0;
   int         pop1 = 0;

   assign req_wdata = {wq1[h1], wq0[h0]};

   always @(posedge clk) begin
      if (wr_pop[0]) begin
         h0   <= h0 + 4'd1;
         pop0 <= pop0 + 1;
      end
      if (wr_pop[1]) begin
         h1   <= h1 + 4'd1;
         pop1 <= pop1 + 1;
      end
   end

   // Read-return log
   logic [7:0]   rlog  [0:63];
   logic [N-1:0] rmask [0:63];
   logic [5:0]   rn = '0;

   always @(negedge clk) begin
      if (rd_valid != '0) begin
         rlog[rn]  <= rd_data;
         rmask[rn] <= rd_valid;
         rn        <= rn + 6'd1;
      end
   end

   // Behavioural I2C master + slave
   logic       slave_ack = 1'b1;
   logic       hang = 1'b0;
   logic [7:0] rbytes [0:3];
   logic [7:0] slog [0:63];
   logic [5:0] slog_n = '0;

   logic       mst_start, mst_done, mst_tx, mst_rx, mst_rw;
   logic [7:0] mst_dout, mst_cnt, mst_j;
   int         mst_state, mst_timer;

   assign m_status   = {4'b0000, mst_rx, mst_tx, mst_done, mst_start};
   assign m_data_out = mst_dout;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         mst_state <= 0;
         mst_start <= 1'b1;
         mst_done  <= 1'b0;
         mst_tx    <= 1'b0;
         mst_rx    <= 1'b0;
         mst_rw    <= 1'b0;
         mst_dout  <= '0;
         mst_cnt   <= '0;
         mst_j     <= '0;
         mst_timer <= 0;
      end else begin
         mst_tx <= 1'b0;
         mst_rx <= 1'b0;
         case (mst_state)
            0: if (m_ready && m_mode == 2'b10) begin
                  mst_start      <= 1'b0;
                  mst_rw         <= m_addr_rw[0];
                  mst_cnt        <= m_data_cnt;
                  slog[slog_n]   <= m_addr_rw;
                  slog_n         <= slog_n + 6'd1;
                  mst_timer      <= BIT;
                  mst_state      <= 1;
               end
            1: if (!hang) begin
                  if (mst_timer > 1) mst_timer <= mst_timer - 1;
                  else if (slave_ack) begin
                     mst_tx    <= 1'b1;
                     mst_j     <= '0;
                     mst_timer <= BIT;
                     mst_state <= 2;
                  end else mst_state <= 3;
               end
            2: if (mst_timer > 1) mst_timer <= mst_timer - 1;
               else begin
                  mst_timer <= BIT;
                  if (!mst_rw) begin
                     slog[slog_n] <= m_data_in;
                     slog_n       <= slog_n + 6'd1;
                     if (mst_j == mst_cnt) mst_state <= 3;
                     else begin
                        mst_tx <= 1'b1;
                        mst_j  <= mst_j + 8'd1;
                     end
                  end else begin
                     mst_dout <= rbytes[mst_j[1:0]];
                     mst_rx   <= 1'b1;
                     if (mst_j == mst_cnt) mst_state <= 3;
                     else mst_j <= mst_j + 8'd1;
                  end
               end
            3: begin
                  mst_done  <= 1'b1;
                  mst_timer <= 3;
                  mst_state <= 4;
               end
            default: if (mst_timer > 1) mst_timer <= mst_timer - 1;
               else begin
                  mst_done  <= 1'b0;
                  mst_start <= 1'b1;
                  mst_state <= 0;
               end
         endcase
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic wait_done(input int budget, output logic [N-1:0] who, output logic [1:0] e);
      who = '0;
      e   = '0;
      for (int k = 0; k < budget; k++) begin
         @(negedge clk);
         if (done != '0) begin
            who = done;
            e   = err;
            return;
         end
      end
      check("done_wait_expired", 32'd0, 32'd1);
   endtask

   initial begin
      #3000000;
      $display("FAIL sim_timeout: bench did not finish in time");
      $fatal(1, "bench stuck");
   end

   logic [N-1:0] who;
   logic [1:0]   e;
   int           p0, p1, n, c0, c1;
   logic [5:0]   s0, r0;
   logic [N-1:0] order [0:5];
   logic [N-1:0] exp_order [0:5];

   initial begin
      for (int i = 0; i < 16; i++) begin
         wq0[i] = 8'(8'h11 * (i + 1));
         wq1[i] = 8'(8'hA0 + i);
      end
      rbytes[0] = 8'h5A;
      rbytes[1] = 8'hC3;
      rbytes[2] = 8'h00;
      rbytes[3] = 8'h00;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_gnt", 32'(gnt), 0);
      check("rst_done", 32'(done), 0);
      check("rst_wr_pop", 32'(wr_pop), 0);
      check("rst_rd_valid", 32'(rd_valid), 0);
      check("rst_err", 32'(err), 0);
      check("rst_m_ready", 32'(m_ready), 0);
      check("rst_m_mode", 32'(m_mode), 0);
      check("rst_m_addr_rw", 32'(m_addr_rw), 0);
      check("rst_m_data_cnt", 32'(m_data_cnt), 0);
      check("rst_m_data_in", 32'(m_data_in), 0);
      check("rst_rd_data", 32'(rd_data), 0);
      rst = 1'b1;
      repeat (2) @(negedge clk);

      // Write: req0, A0, 3 bytes 11 22 33
      p0 = pop0; s0 = slog_n;
      req_addr_rw[7:0] = 8'hA0; req_cnt[7:0] = 8'd2; req[0] = 1'b1;
      wait_done(2000, who, e);
      req[0] = 1'b0;
      check("wr_done_who", 32'(who), 32'h1);
      check("wr_err", 32'(e), 0);
      check("wr_pops", 32'(pop0 - p0), 3);
      check("wr_slave_addr", 32'(slog[s0]), 32'hA0);
      check("wr_slave_b0", 32'(slog[s0 + 6'd1]), 32'h11);
      check("wr_slave_b1", 32'(slog[s0 + 6'd2]), 32'h22);
      check("wr_slave_b2", 32'(slog[s0 + 6'd3]), 32'h33);

      // Read: req1, A1, 2 bytes 5A C3
      p1 = pop1; r0 = rn;
      req_addr_rw[15:8] = 8'hA1; req_cnt[15:8] = 8'd1; req[1] = 1'b1;
      wait_done(2000, who, e);
      req[1] = 1'b0;
      check("rd_done_who", 32'(who), 32'h2);
      check("rd_err", 32'(e), 0);
      check("rd_count", 32'(rn - r0), 2);
      check("rd_byte0", 32'(rlog[r0]), 32'h5A);
      check("rd_byte1", 32'(rlog[r0 + 6'd1]), 32'hC3);
      check("rd_valid_owner", 32'(rmask[r0]), 32'h2);
      check("rd_no_pops", 32'(pop1 - p1), 0);

      // Contention: both read requesters held for 3 transactions each
      req_addr_rw = {8'hA3, 8'hA1}; req_cnt = '0;
      exp_order[0] = 2'b01; exp_order[1] = 2'b10; exp_order[2] = 2'b01;
      exp_order[3] = 2'b10; exp_order[4] = 2'b01; exp_order[5] = 2'b10;
      c0 = 0; c1 = 0;
      req = 2'b11;
      for (int k = 0; k < 6; k++) begin
         wait_done(2000, who, e);
         order[k] = who;
         if (who == 2'b01) begin c0++; if (c0 == 3) req[0] = 1'b0; end
         if (who == 2'b10) begin c1++; if (c1 == 3) req[1] = 1'b0; end
      end
      req = '0;
      for (int k = 0; k < 6; k++) check($sformatf("rr_order_%0d", k), 32'(order[k]), 32'(exp_order[k]));

      // Address NACK: req0 write to 0x90, no slave
      slave_ack = 1'b0;
      p0 = pop0; s0 = slog_n;
      req_addr_rw[7:0] = 8'h90; req_cnt[7:0] = 8'd0; req[0] = 1'b1;
      wait_done(2000, who, e);
      req[0] = 1'b0;
      slave_ack = 1'b1;
      check("nack_done_who", 32'(who), 32'h1);
      check("nack_err", 32'(e), 32'h1);
      check("nack_pops_grant_only", 32'(pop0 - p0), 1);
      check("nack_slave_bytes", 32'(slog_n - s0), 1);

      // Reset during RUN of a write, then a clean write
      req_addr_rw[7:0] = 8'hA0; req_cnt[7:0] = 8'd2; req[0] = 1'b1;
      n = 0;
      while (mst_state != 2 && n < 500) begin @(negedge clk); n++; end
      check("rstrun_reached_run", 32'(mst_state == 2), 1);
      #2 rst = 1'b0;
      #1;
      check("rstrun_gnt", 32'(gnt), 0);
      check("rstrun_m_ready", 32'(m_ready), 0);
      check("rstrun_m_mode", 32'(m_mode), 0);
      @(negedge clk); @(negedge clk);
      p0 = pop0;
      rst = 1'b1;
      wait_done(2000, who, e);
      req[0] = 1'b0;
      check("rstrun_done_who", 32'(who), 32'h1);
      check("rstrun_err", 32'(e), 0);
      check("rstrun_pops", 32'(pop0 - p0), 3);

      // Watchdog: slave holds the bus, abort 5000 cycles after launch
      hang = 1'b1;
      req_addr_rw[7:0] = 8'hA0; req_cnt[7:0] = 8'd0; req[0] = 1'b1;
      n = 0;
      while (!m_ready && n < 100) begin @(negedge clk); n++; end
      check("to_launched", 32'(m_ready), 1);
      n = 0;
      who = '0; e = '0;
      while (n < 6000) begin
         @(negedge clk);
         n++;
         if (done != '0) begin who = done; e = err; break; end
      end
      check("to_cycles", 32'(n), 5000);
      check("to_done_who", 32'(who), 32'h1);
      check("to_err", 32'(e), 32'h2);
      check("to_m_ready", 32'(m_ready), 0);
      req[0] = 1'b0;
      p0 = pop0; r0 = rn;
      @(negedge clk);
      check("to_gnt_clear", 32'(gnt), 0);
      repeat (20) @(negedge clk);
      check("to_no_pops", 32'(pop0 - p0), 0);
      check("to_no_rd", 32'(rn - r0), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
